bk_add_arbiter: RTL and testbench
=================================

# bk_add_arbiter

Round-robin arbiter and two-stage pipeline that shares one 12-bit Brent-Kung adder instance among NREQ requesters. Each requester presents a 12-bit operand pair under a valid/ready handshake. The block grants one requester per cycle, registers its operands, and adds them in the shared adder. It returns the 13-bit sum, tagged with the requester index, on a single response channel that supports backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of the requester index; must equal clog2(NREQ)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_a  input  NREQ*12  operand A; requester i occupies bits [12i+11:12i]
- req_b  input  NREQ*12  operand B; same packing as req_a
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accept
- rsp_sum  output  13  sum; bit 12 is the adder carry-out
- rsp_id  output  IDW  index of the requester that produced rsp_sum
- busy  output  1  high when either pipeline stage holds data
- cout_cnt  output  8  saturating count of delivered responses with rsp_sum[12]=1

## Operation
- **Adder binding.** One adder instance, bit-pair interleaved: adder INPUTS[2k]=op_a[k], INPUTS[2k+1]=op_b[k]. rsp_sum[k] is taken from OUTS[k] for k=0..12. No other adder exists in the block.
- **Stage S1 (operand register).** Holds op_valid, op_a, op_b, op_id.
- **Stage S2 (response register).** Holds rsp_valid, rsp_sum, rsp_id.
- **Advance conditions.**
  - adv2 = !rsp_valid | rsp_ready
  - adv1 = !op_valid | adv2
- **Arbitration.**
  - Priority pointer ptr (IDW bits).
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NREQ.
  - req_ready[g]=adv1 for the granted g only; all other bits are 0. No grant when no req_valid is set.
  - On a handshake (req_valid[g] & req_ready[g]): S1 loads {1, req_a[g], req_b[g], g}, and ptr becomes (g+1) mod NREQ.
  - ptr is unchanged on cycles with no handshake.
- **S1 to S2.** On adv2 & op_valid: S2 loads {1, adder sum, op_id}. If adv1 occurs with no new handshake, op_valid clears.
- **S2 drain.** On rsp_valid & rsp_ready & !(op_valid & adv2): rsp_valid clears.
- **Simultaneous events.** Drain, S1→S2 move and a new grant can all occur in one cycle. Full throughput is 1 response per cycle.
- **Stability under stall.** While rsp_valid & !rsp_ready, rsp_sum and rsp_id hold stable. S1 holds. No new grant occurs if S1 is full.
- **Data integrity.** No request is lost or duplicated.
- **Request-side rules.** Requesters must hold req_a/req_b stable while req_valid is high and unaccepted. The block's arbitration does not depend on that stability; only the captured values matter.
- **cout_cnt.** Increments on each rsp handshake where rsp_sum[12]=1. It saturates at 255 and does not wrap.
- **busy** = op_valid | rsp_valid.
- **Reset values (rst=1 at a clock edge).** ptr=0, op_valid=0, rsp_valid=0, cout_cnt=0; rsp_sum=0, rsp_id=0 and the S1 data registers are cleared. In-flight data is discarded.
- **During reset.** req_ready=0 while rst is high.

## Timing
- Request accepted at edge N → rsp_valid=1 after edge N+1, with no backpressure. Latency is 2 cycles.
- req_ready is combinational from req_valid, ptr, op_valid, rsp_valid and rsp_ready. There is no combinational path from req_a/req_b to any output.
- The adder is combinational between S1 and S2. The timing path is op regs → adder → S2 regs.
- Reset is synchronous: behaviour changes only at the edge sampling rst=1. The first grant is possible in the cycle after rst deasserts.

## Test plan
- **Single request.** Reset, then req_valid=0001 with a=0xFFF, b=0x001, rsp_ready=1.
  - req_ready=0001 for one cycle.
  - Two cycles later rsp_valid=1, rsp_sum=0x1000, rsp_id=0, cout_cnt=1.
- **Round-robin fairness.** All four requesters valid continuously, rsp_ready=1.
  - Grant order is 0,1,2,3,0,1,…
  - One response per cycle.
  - rsp_id sequence matches the grant order.
- **Backpressure.** Stream from requester 2 (a=k, b=k for k=1..6), holding rsp_ready=0 for 5 cycles mid-stream.
  - rsp_sum/rsp_id stay stable.
  - req_ready=0 once both stages are full.
  - All six sums 2k are delivered in order with none missing.
- **Pointer skip and wrap.** ptr=3, req_valid=0101.
  - Grant goes to 0, then 2.
  - With only requester 3 valid afterward, ptr wraps to 0 after its grant.
- **Reset mid-operation.** Assert rst with both stages full.
  - Next cycle: rsp_valid=0, busy=0, cout_cnt=0, req_ready=0.
  - After release, requester 0 is granted first even if requester 3 is also valid.
- **Counter saturation.** Deliver 300 responses with a=0x800, b=0x800 (sum 0x1000).
  - cout_cnt stops at 255.
  - Deliver a=0, b=0: rsp_sum=0 and cout_cnt stays 255.

Source files
------------

// File: rtl/bk_add_arbiter.sv
// bk_add_arbiter: round-robin arbiter feeding a shared 12-bit Brent-Kung adder
// through an operand stage and a response stage with backpressure.
module bk_adder12 (
    input  logic [23:0] inputs,
    output logic [12:0] outs
);
    logic [11:0] p, g, gg, pp;
    always_comb begin
        for (int k = 0; k < 12; k++) begin
            p[k] = inputs[2*k] ^ inputs[2*k+1];
            g[k] = inputs[2*k] & inputs[2*k+1];
        end
        gg = g;
        pp = p;
        // up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 12; i++)
                if ((i + 1) % (2 << l) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
                    pp[i] = pp[i] & pp[i-(1<<l)];
                end
        for (int l = 2; l >= 0; l--)
            for (int i = 0; i < 12; i++)
                if ((i + 1) % (2 << l) == (1 << l) && i >= (2 << l)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
                    pp[i] = pp[i] & pp[i-(1<<l)];
                end
        outs = {gg[11], p ^ {gg[10:0], 1'b0}};
    end
endmodule

module bk_add_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*12-1:0] req_a,
    input  logic [NREQ*12-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [12:0]        rsp_sum,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy,
    output logic [7:0]         cout_cnt
);
    logic [IDW-1:0] ptr_q, ptr_d, gnt, idx, op_id_q, rsp_id_q;
    logic [11:0] op_a_q, op_b_q;
    logic [12:0] sum, rsp_sum_q;
    logic [7:0] cnt_q;
    logic [23:0] pairs;
    logic op_valid_q, rsp_valid_q, found, hs, adv1, adv2;

    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        // descending scan so the smallest offset from ptr wins
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx = IDW'((int'(ptr_q) + j) % NREQ);
            if (req_valid[idx]) begin
                gnt = idx;
                found = 1'b1;
            end
        end
        adv2 = !rsp_valid_q | rsp_ready;
        adv1 = !op_valid_q | adv2;
        hs = found & adv1 & !rst;
        req_ready = hs ? NREQ'(1) << gnt : '0;
        ptr_d = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
        for (int k = 0; k < 12; k++) begin
            pairs[2*k] = op_a_q[k];
            pairs[2*k+1] = op_b_q[k];
        end
    end

    bk_adder12 u_add (.inputs(pairs), .outs(sum));

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            op_valid_q <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            op_id_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q <= '0;
            rsp_id_q <= '0;
            cnt_q <= '0;
        end else begin
            if (adv1) begin
                op_valid_q <= hs;
                if (hs) begin
                    op_a_q <= req_a[12*int'(gnt) +: 12];
                    op_b_q <= req_b[12*int'(gnt) +: 12];
                    op_id_q <= gnt;
                    ptr_q <= ptr_d;
                end
            end
            if (adv2) begin
                rsp_valid_q <= op_valid_q;
                if (op_valid_q) begin
                    rsp_sum_q <= sum;
                    rsp_id_q <= op_id_q;
                end
            end
            if (rsp_valid_q && rsp_ready && rsp_sum_q[12] && cnt_q != 8'hFF)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum = rsp_sum_q;
    assign rsp_id = rsp_id_q;
    assign busy = op_valid_q | rsp_valid_q;
    assign cout_cnt = cnt_q;
endmodule

// File: tb/tb_bk_add_arbiter.sv
// tb_bk_add_arbiter: directed vectors and corner-case sequences for bk_add_arbiter.
module tb_bk_add_arbiter;
    logic clk = 1'b0, rst;
    logic [3:0] req_valid, req_ready;
    logic [47:0] req_a, req_b;
    logic rsp_valid, rsp_ready, busy;
    logic [12:0] rsp_sum, prev_sum;
    logic [1:0] rsp_id, prev_id;
    logic [7:0] cout_cnt;
    int tests = 0, fails = 0;
    int k, sent, got, exp_cnt;
    logic [12:0] q[$];

    typedef struct {
        int          id;
        logic [11:0] a;
        logic [11:0] b;
        logic [12:0] s;
    } vec_t;
    vec_t tbl[10];

    bk_add_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy), .cout_cnt(cout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [11:0] a, input logic [11:0] b);
        req_a[id*12 +: 12] = a;
        req_b[id*12 +: 12] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic xact(input int id, input logic [11:0] a, input logic [11:0] b, input logic [12:0] s);
        @(negedge clk);
        req_valid = 4'(1 << id);
        set_req(id, a, b);
        #1;
        chk("xact_ready", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("xact_busy", 32'(busy), 1);
        @(negedge clk);
        #1;
        chk("xact_rsp_valid", 32'(rsp_valid), 1);
        chk("xact_rsp_sum", 32'(rsp_sum), 32'(s));
        chk("xact_rsp_id", 32'(rsp_id), 32'(id));
    endtask

    initial begin
        tbl[0] = '{1, 12'h123, 12'h456, 13'h0579};
        tbl[1] = '{2, 12'hABC, 12'h544, 13'h1000};
        tbl[2] = '{3, 12'h000, 12'h000, 13'h0000};
        tbl[3] = '{0, 12'hFFF, 12'hFFF, 13'h1FFE};
        tbl[4] = '{1, 12'h555, 12'hAAA, 13'h0FFF};
        tbl[5] = '{2, 12'h800, 12'h7FF, 13'h0FFF};
        tbl[6] = '{3, 12'h0F0, 12'h010, 13'h0100};
        tbl[7] = '{0, 12'h7FF, 12'h001, 13'h0800};
        tbl[8] = '{1, 12'hFFF, 12'h001, 13'h1000};
        tbl[9] = '{2, 12'h3A5, 12'h0C6, 13'h046B};

        do_reset();
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cout", 32'(cout_cnt), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_id", 32'(rsp_id), 0);

        xact(0, 12'hFFF, 12'h001, 13'h1000);
        @(negedge clk);
        #1;
        chk("single_cout", 32'(cout_cnt), 1);
        exp_cnt = 1;
        foreach (tbl[i]) begin
            xact(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].s);
            if (tbl[i].s[12]) exp_cnt++;
        end
        @(negedge clk);
        #1;
        chk("table_cout", 32'(cout_cnt), 32'(exp_cnt));

        // last table grant was requester 2, so ptr=3 here
        @(negedge clk);
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        set_req(0, 12'h001, 12'h001);
        set_req(3, 12'h002, 12'h002);
        #1;
        chk("rmo_grant3", 32'(req_ready), 32'h8);
        @(negedge clk);
        #1;
        chk("rmo_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1;
        chk("rmo_full_ready", 32'(req_ready), 0);
        chk("rmo_full_busy", 32'(busy), 1);
        chk("rmo_full_id", 32'(rsp_id), 3);
        rst = 1'b1;
        #1;
        chk("rmo_ready_in_rst", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("rmo_rsp_valid", 32'(rsp_valid), 0);
        chk("rmo_busy", 32'(busy), 0);
        chk("rmo_cout", 32'(cout_cnt), 0);
        chk("rmo_ready", 32'(req_ready), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rmo_first_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 12'(256 * (i + 1)), 12'(i));
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
                chk("rr_rsp_sum", 32'(rsp_sum), 32'(257 * (((c - 2) % 4) + 1) - 1));
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);

        do_reset();
        k = 1;
        q.delete();
        for (int c = 0; c < 40 && q.size() < 6; c++) begin
            rsp_ready = !(c >= 3 && c <= 7);
            req_valid = (k <= 6) ? 4'b0100 : 4'b0000;
            set_req(2, 12'(k), 12'(k));
            #1;
            if (c >= 3 && c <= 7) begin
                chk("bp_ready_full", 32'(req_ready), 0);
                chk("bp_rsp_valid", 32'(rsp_valid), 1);
            end
            if (c >= 4 && c <= 7) begin
                chk("bp_sum_stable", 32'(rsp_sum), 32'(prev_sum));
                chk("bp_id_stable", 32'(rsp_id), 32'(prev_id));
            end
            prev_sum = rsp_sum;
            prev_id = rsp_id;
            if (req_ready[2]) k++;
            if (rsp_valid && rsp_ready) q.push_back(rsp_sum);
            @(negedge clk);
        end
        chk("bp_count", 32'(q.size()), 6);
        foreach (q[i]) chk("bp_order", 32'(q[i]), 32'(2 * (i + 1)));
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);

        do_reset();
        xact(2, 12'h001, 12'h001, 13'h0002);
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        chk("ptr_skip_g0", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1;
        chk("ptr_skip_g2", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        chk("ptr_g3", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        chk("ptr_wrap_g0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        do_reset();
        set_req(1, 12'h800, 12'h800);
        sent = 0;
        got = 0;
        for (int c = 0; c < 400 && got < 300; c++) begin
            req_valid = (sent < 300) ? 4'b0010 : 4'b0000;
            #1;
            if (req_ready[1]) sent++;
            if (rsp_valid) got++;
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        chk("sat_count", 32'(got), 300);
        chk("sat_cout", 32'(cout_cnt), 255);
        chk("sat_idle", 32'(busy), 0);
        xact(1, 12'h000, 12'h000, 13'h0000);
        @(negedge clk);
        #1;
        chk("sat_hold", 32'(cout_cnt), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
